// File: rtl/multiplexed_display_n_if.sv
// Load-side bus of the multiplexed display driver: the formatting logic pushes a
// complete frame of digit data with a one-cycle load and gets a load_ack once it is shown.
interface multiplexed_display_n_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_in;
  logic                    colon_in;
  logic                    zero_suppress;
  logic                    load_ack;

  modport master (
    output load, digits_in, dp_in, blink_in, colon_in, zero_suppress,
    input  load_ack
  );

  modport slave (
    input  load, digits_in, dp_in, blink_in, colon_in, zero_suppress,
    output load_ack
  );
endinterface

// File: rtl/multiplexed_display_n.sv
// N-digit time-multiplexed 7-segment driver with double-buffered frame data,
// inter-digit blanking, leading-zero suppression, per-digit blink and decimal points.
module multiplexed_display_n #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1,
  parameter int BLANK_CYCLES = 1,
  parameter int BLINK_DIV    = 250
) (
  input  logic                  clk_500Hz,
  input  logic                  reset,
  multiplexed_display_n_if.slave bus,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  colon,
  output logic                  frame_done
);

  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PHASE_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W     = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic {
    SHOW,
    BLANK
  } scan_state_t;

  scan_state_t state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             boundary;

  logic [4*NUM_DIGITS-1:0] sh_digits, act_digits;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
  logic [NUM_DIGITS-1:0]   sh_blink, act_blink;
  logic                    sh_colon, act_colon;
  logic                    sh_zs, act_zs;
  logic                    pending;
  logic                    ack_pend;
  logic                    load_ack_r;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic [NUM_DIGITS-1:0] suppress;
  logic                  all_zero;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  cur_supp;
  logic [NUM_DIGITS-1:0] anode_nxt;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b1111110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      state <= SHOW;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // boundary marks the final cycle of a frame, the only point where new data may go live
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 1'b1;
    boundary  = 1'b0;
    unique case (state)
      SHOW: begin
        if (cnt == DWELL_LAST) begin
          cnt_nxt = '0;
          if (BLANK_CYCLES > 0) begin
            state_nxt = BLANK;
          end else begin
            idx_nxt  = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            boundary = (idx == LAST_IDX);
          end
        end
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SHOW;
          idx_nxt   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
          boundary  = (idx == LAST_IDX);
        end
      end
      default: begin
        state_nxt = SHOW;
        idx_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A load landing on the boundary bypasses the shadow so it is not delayed a whole frame
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      sh_digits  <= {NUM_DIGITS{4'hF}};
      sh_dp      <= '0;
      sh_blink   <= '0;
      sh_colon   <= 1'b0;
      sh_zs      <= 1'b0;
      act_digits <= {NUM_DIGITS{4'hF}};
      act_dp     <= '0;
      act_blink  <= '0;
      act_colon  <= 1'b0;
      act_zs     <= 1'b0;
      pending    <= 1'b0;
      ack_pend   <= 1'b0;
    end else begin
      ack_pend <= 1'b0;
      if (bus.load) begin
        sh_digits <= bus.digits_in;
        sh_dp     <= bus.dp_in;
        sh_blink  <= bus.blink_in;
        sh_colon  <= bus.colon_in;
        sh_zs     <= bus.zero_suppress;
        pending   <= 1'b1;
      end
      if (boundary && bus.load) begin
        act_digits <= bus.digits_in;
        act_dp     <= bus.dp_in;
        act_blink  <= bus.blink_in;
        act_colon  <= bus.colon_in;
        act_zs     <= bus.zero_suppress;
        pending    <= 1'b0;
        ack_pend   <= 1'b1;
      end else if (boundary && pending) begin
        act_digits <= sh_digits;
        act_dp     <= sh_dp;
        act_blink  <= sh_blink;
        act_colon  <= sh_colon;
        act_zs     <= sh_zs;
        pending    <= 1'b0;
        ack_pend   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Suppression runs left to right and stops at the first non-zero digit; the rightmost always shows
  always_comb begin
    all_zero = 1'b1;
    suppress = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      all_zero    = all_zero && (act_digits[4*i +: 4] == 4'h0);
      suppress[i] = act_zs && all_zero && (i != NUM_DIGITS - 1);
    end
  end

  always_comb begin
    cur_nib   = 4'hF;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_supp  = 1'b0;
    anode_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = act_digits[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blink = act_blink[i];
        cur_supp  = suppress[i];
        if (state == SHOW) begin
          anode_nxt[i] = 1'b0;
        end
      end
    end
  end

  // Blinked digits keep their anode slot so the scan duty cycle never changes
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      anode      <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      colon      <= 1'b0;
      frame_done <= 1'b0;
      load_ack_r <= 1'b0;
    end else begin
      anode      <= anode_nxt;
      colon      <= act_colon;
      frame_done <= boundary;
      load_ack_r <= ack_pend;
      if (state == SHOW && !(cur_blink && blink_phase)) begin
        seg <= cur_supp ? 7'h7F : decode(cur_nib);
        dp  <= ~cur_dp;
      end else begin
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

  assign bus.load_ack = load_ack_r;

endmodule
